// File: rtl/binary_2_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package binary_2_bcd_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StFinish = 2'd2
  } state_e;

  localparam logic [3:0] BLANK_NIBBLE = 4'hF;
  localparam logic [3:0] ADD3_THRESH  = 4'd5;

  // Number of decimal digits needed to print val.
  function automatic int unsigned dec_digits(input int unsigned val);
    int unsigned v;
    int unsigned n;
    v = val;
    n = 1;
    for (int i = 0; i < 10; i++) begin
      if (v >= 10) begin
        v = v / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
  import binary_2_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = (digit >= ADD3_THRESH) ? digit + 4'd3 : digit;
  end

endmodule

// File: rtl/binary_2_bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, result held until the next
// conversion, with optional leading-zero blanking and a display enable on the output.
module binary_2_bcd_seq
  import binary_2_bcd_pkg::*;
#(
  parameter int unsigned BIN_W    = 8,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned MAX_VAL  = (32'd1 << BIN_W) - 32'd1,
  parameter bit          LZ_BLANK = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary_in,
  input  logic                  disp_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W);

  if (BIN_W < 4 || BIN_W > 16) begin : g_bad_bin_w
    $error("binary_2_bcd_seq: BIN_W must be in 4..16");
  end
  if (DIGITS < dec_digits((32'd1 << BIN_W) - 32'd1)) begin : g_bad_digits
    $error("binary_2_bcd_seq: DIGITS too small for 2**BIN_W-1");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [BcdW-1:0]   bcd_adj;
  logic              oor_q, oor_d;
  logic [BcdW-1:0]   result_q, result_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              lz_lead;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (bcd_q[4*g +: 4]),
      .adjusted (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    oor_d    = oor_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          bin_d   = binary_in;
          bcd_d   = '0;
          cnt_d   = '0;
          oor_d   = (32'(binary_in) > MAX_VAL);
        end
      end
      StShift: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + CntW'(1);
        if (cnt_q == CntW'(BIN_W - 1)) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        // done is registered so it rises together with the freshly loaded result.
        state_d  = StIdle;
        done_d   = 1'b1;
        err_d    = oor_q;
        result_d = oor_q ? {DIGITS{BLANK_NIBBLE}} : bcd_q;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      oor_q    <= 1'b0;
      result_q <= {DIGITS{BLANK_NIBBLE}};
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      oor_q    <= oor_d;
      result_q <= result_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign err  = err_q;

  // Units digit is never blanked; an all-F result has no zero digits so passes through.
  always_comb begin
    bcd_out = result_q;
    lz_lead = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (LZ_BLANK && lz_lead && (result_q[4*i +: 4] == 4'h0)) begin
        bcd_out[4*i +: 4] = BLANK_NIBBLE;
      end else begin
        lz_lead = 1'b0;
      end
    end
    if (!disp_en) begin
      bcd_out = {DIGITS{BLANK_NIBBLE}};
    end
  end

endmodule
